// File: rtl/shift_pkg.sv
// Purpose: shared types and helpers for the universal shift register and its burst controller.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package shift_pkg;

  // Operation select, encoded exactly as driven on the mode input.
  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHR  = 3'b010,
    M_SHL  = 3'b011,
    M_ROR  = 3'b100,
    M_ROL  = 3'b101,
    M_ASR  = 3'b110,
    M_CLR  = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Only shift-class modes may start a burst; HOLD/LOAD/CLR never do.
  function automatic logic is_shift(input mode_t m);
    return (m inside {M_SHR, M_SHL, M_ROR, M_ROL, M_ASR});
  endfunction

endpackage

// File: rtl/burst_ctrl.sv
// Purpose: burst-shift FSM; picks the op applied to the data register each edge.
// Latency: start sampled in IDLE -> BURST next cycle; done one cycle after the last shift.
// Backpressure: none; inputs are ignored outside IDLE.
//
// Ports:
//   clk_2, reset_n        clock, async active-low reset
//   i_mode                requested op (raw mode input)
//   i_start, i_burst_len  burst request and length (saturated to NBITS_DATA)
//   o_op                  op the datapath applies at the next edge
//   o_busy, o_done        BURST / DONE state decode
module burst_ctrl
  import shift_pkg::*;
#(
  parameter int NBITS_DATA = 8,
  parameter int NBITS_CNT  = $clog2(NBITS_DATA) + 1
) (
  input  logic                 clk_2,
  input  logic                 reset_n,
  input  mode_t                i_mode,
  input  logic                 i_start,
  input  logic [NBITS_CNT-1:0] i_burst_len,
  output mode_t                o_op,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [NBITS_CNT-1:0] MAX_LEN = NBITS_CNT'(NBITS_DATA);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NBITS_CNT-1:0] r_cnt;
  logic [NBITS_CNT-1:0] w_cnt_nxt;
  mode_t                r_op;
  mode_t                w_op_nxt;
  logic [NBITS_CNT-1:0] w_len_sat;
  logic                 w_burst_req;

  // More than NBITS_DATA shifts is never useful, so clamp the length at capture.
  assign w_len_sat   = (i_burst_len > MAX_LEN) ? MAX_LEN : i_burst_len;
  assign w_burst_req = i_start && is_shift(i_mode);

  // State register
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= M_HOLD;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    case (r_state)
      IDLE: begin
        if (w_burst_req) begin
          w_op_nxt    = i_mode;
          w_cnt_nxt   = w_len_sat;
          // A zero-length burst still reports completion.
          w_state_nxt = (w_len_sat != '0) ? BURST : DONE;
        end
      end
      BURST: begin
        w_cnt_nxt = r_cnt - NBITS_CNT'(1);
        if (r_cnt == NBITS_CNT'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_op   = M_HOLD;
    o_busy = (r_state == BURST);
    o_done = (r_state == DONE);
    case (r_state)
      // The capture edge of a burst holds the data; shifting starts next edge.
      IDLE:    o_op = w_burst_req ? M_HOLD : i_mode;
      BURST:   o_op = r_op;
      default: o_op = M_HOLD;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Purpose: universal shift register (load/hold/clear, logical/arith shifts, rotates) with burst mode.
// Latency: direct ops visible after 1 edge; an L-shift burst completes L+1 edges after start.
// Backpressure: none; busy flags that mode/start/burst_len are being ignored.
//
// Ports:
//   clk_2, reset_n             clock, async active-low reset
//   mode, paralelo             op select and parallel load data
//   serial_in_r, serial_in_l   bits entering MSB (SHR) / LSB (SHL)
//   start, burst_len           burst request and shift count
//   saida, so_lsb, so_msb      register contents and its end bits
//   busy, done                 burst in progress / one-cycle completion pulse
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int NBITS_DATA = 8,
  parameter int NBITS_CNT  = $clog2(NBITS_DATA) + 1
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  input  logic [2:0]            mode,
  input  logic [NBITS_DATA-1:0] paralelo,
  input  logic                  serial_in_r,
  input  logic                  serial_in_l,
  input  logic                  start,
  input  logic [NBITS_CNT-1:0]  burst_len,
  output logic [NBITS_DATA-1:0] saida,
  output logic                  so_lsb,
  output logic                  so_msb,
  output logic                  busy,
  output logic                  done
);

  logic [NBITS_DATA-1:0] r_saida;
  logic [NBITS_DATA-1:0] w_saida_nxt;
  mode_t                 w_mode;
  mode_t                 w_op;

  assign w_mode = mode_t'(mode);

  burst_ctrl #(
    .NBITS_DATA (NBITS_DATA),
    .NBITS_CNT  (NBITS_CNT)
  ) u_burst_ctrl (
    .clk_2       (clk_2),
    .reset_n     (reset_n),
    .i_mode      (w_mode),
    .i_start     (start),
    .i_burst_len (burst_len),
    .o_op        (w_op),
    .o_busy      (busy),
    .o_done      (done)
  );

  always_comb begin
    w_saida_nxt = r_saida;
    case (w_op)
      M_HOLD: w_saida_nxt = r_saida;
      M_LOAD: w_saida_nxt = paralelo;
      M_SHR:  w_saida_nxt = {serial_in_r, r_saida[NBITS_DATA-1:1]};
      M_SHL:  w_saida_nxt = {r_saida[NBITS_DATA-2:0], serial_in_l};
      M_ROR:  w_saida_nxt = {r_saida[0], r_saida[NBITS_DATA-1:1]};
      M_ROL:  w_saida_nxt = {r_saida[NBITS_DATA-2:0], r_saida[NBITS_DATA-1]};
      M_ASR:  w_saida_nxt = {r_saida[NBITS_DATA-1], r_saida[NBITS_DATA-1:1]};
      M_CLR:  w_saida_nxt = '0;
      default: w_saida_nxt = r_saida;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_saida <= '0;
    end else begin
      r_saida <= w_saida_nxt;
    end
  end

  assign saida  = r_saida;
  assign so_lsb = r_saida[0];
  assign so_msb = r_saida[NBITS_DATA-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Purpose: scoreboard bench for univ_shift_reg (NBITS_DATA=8) with directed vectors.
// Latency: expectations are queued per edge and checked 1 time unit after that edge.
// Backpressure: not applicable.
module tb_univ_shift_reg;

  localparam int NB  = 8;
  localparam int NBC = 4;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHR = 3'b010, SHL = 3'b011;
  localparam logic [2:0] ROR  = 3'b100, ROL  = 3'b101, ASR = 3'b110, CLR = 3'b111;

  logic           clk_2 = 1'b0;
  logic           reset_n;
  logic [2:0]     mode;
  logic [NB-1:0]  paralelo;
  logic           serial_in_r;
  logic           serial_in_l;
  logic           start;
  logic [NBC-1:0] burst_len;
  logic [NB-1:0]  saida;
  logic           so_lsb;
  logic           so_msb;
  logic           busy;
  logic           done;

  typedef struct packed {
    logic [NB-1:0] s;
    logic          b;
    logic          d;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  univ_shift_reg #(.NBITS_DATA(NB), .NBITS_CNT(NBC)) dut (
    .clk_2       (clk_2),
    .reset_n     (reset_n),
    .mode        (mode),
    .paralelo    (paralelo),
    .serial_in_r (serial_in_r),
    .serial_in_l (serial_in_l),
    .start       (start),
    .burst_len   (burst_len),
    .saida       (saida),
    .so_lsb      (so_lsb),
    .so_msb      (so_msb),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_2 = ~clk_2;

  task automatic compare(input string nm, input exp_t e);
    checks++;
    if (saida !== e.s || busy !== e.b || done !== e.d ||
        so_lsb !== e.s[0] || so_msb !== e.s[NB-1]) begin
      errors++;
      $display("FAIL %s: got saida=%h busy=%b done=%b lsb=%b msb=%b, want saida=%h busy=%b done=%b lsb=%b msb=%b",
               nm, saida, busy, done, so_lsb, so_msb, e.s, e.b, e.d, e.s[0], e.s[NB-1]);
    end
  endtask

  // Inputs are already driven; queue what the DUT must show after the coming edge.
  task automatic step(input string nm, input logic [NB-1:0] es, input logic eb, input logic ed);
    exp_t e;
    e.s = es;
    e.b = eb;
    e.d = ed;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk_2);
  endtask

  task automatic load(input logic [NB-1:0] v);
    mode = LOAD; paralelo = v; start = 1'b0;
    step("load", v, 1'b0, 1'b0);
  endtask

  // Monitor: one queued expectation is consumed per edge.
  initial begin
    forever begin
      @(posedge clk_2);
      #1;
      if (exp_q.size() > 0) begin
        compare(name_q.pop_front(), exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [NB-1:0] v;
    exp_t          rst_e;
    rst_e = '0;

    reset_n = 1'b0; mode = HOLD; paralelo = '0; serial_in_r = 1'b0;
    serial_in_l = 1'b0; start = 1'b0; burst_len = '0;
    #2;
    compare("reset_state", rst_e);
    @(negedge clk_2);
    reset_n = 1'b1;

    // Direct ops
    load(8'hA5);
    mode = SHR; serial_in_r = 1'b1; step("shr_in1", 8'hD2, 1'b0, 1'b0);
    serial_in_r = 1'b0;
    load(8'hA5);
    mode = SHL; serial_in_l = 1'b0; step("shl_in0", 8'h4A, 1'b0, 1'b0);
    load(8'hA5);
    mode = ROL; step("rol", 8'h4B, 1'b0, 1'b0);
    load(8'hA5);
    mode = ROR; step("ror", 8'hD2, 1'b0, 1'b0);
    load(8'hA5);
    mode = ASR; step("asr_neg", 8'hD2, 1'b0, 1'b0);
    load(8'h25);
    mode = ASR; step("asr_pos", 8'h12, 1'b0, 1'b0);
    mode = CLR; step("clr", 8'h00, 1'b0, 1'b0);
    load(8'h3C);
    mode = HOLD; step("hold", 8'h3C, 1'b0, 1'b0);

    // Burst ROR x3 from 0x81; mode/len changes during the burst must be ignored
    load(8'h81);
    mode = ROR; start = 1'b1; burst_len = 4'd3;
    step("burst_capture", 8'h81, 1'b1, 1'b0);
    mode = CLR; start = 1'b0; burst_len = 4'd0;
    step("burst_1", 8'hC0, 1'b1, 1'b0);
    step("burst_2", 8'h60, 1'b1, 1'b0);
    step("burst_3_done", 8'h30, 1'b0, 1'b1);
    step("done_holds", 8'h30, 1'b0, 1'b0);
    mode = HOLD;

    // Zero-length burst
    mode = SHR; start = 1'b1; burst_len = 4'd0;
    step("len0_done", 8'h30, 1'b0, 1'b1);
    mode = HOLD; start = 1'b0;
    step("len0_idle", 8'h30, 1'b0, 1'b0);

    // start with a non-shift mode is a plain load
    mode = LOAD; paralelo = 8'h5A; start = 1'b1; burst_len = 4'd3;
    step("start_load", 8'h5A, 1'b0, 1'b0);
    start = 1'b0;

    // burst_len=15 saturates to 8 ROL shifts; start stays high for a back-to-back burst
    load(8'h01);
    mode = ROL; start = 1'b1; burst_len = 4'd15;
    step("sat_capture", 8'h01, 1'b1, 1'b0);
    v = 8'h01;
    for (int i = 1; i <= 8; i++) begin
      v = {v[NB-2:0], v[NB-1]};
      step("sat_shift", v, (i < 8), (i == 8));
    end
    step("b2b_idle_gap", v, 1'b0, 1'b0);
    step("b2b_capture", v, 1'b1, 1'b0);
    start = 1'b0; mode = HOLD;
    for (int i = 1; i <= 8; i++) begin
      v = {v[NB-2:0], v[NB-1]};
      step("b2b_shift", v, (i < 8), (i == 8));
    end
    step("b2b_idle", v, 1'b0, 1'b0);

    // Reset during a 5-shift SHR burst
    load(8'hF0);
    mode = SHR; serial_in_r = 1'b0; start = 1'b1; burst_len = 4'd5;
    step("rst_burst_capture", 8'hF0, 1'b1, 1'b0);
    start = 1'b0; mode = HOLD;
    step("rst_burst_1", 8'h78, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    compare("reset_mid_burst", rst_e);
    @(negedge clk_2);
    reset_n = 1'b1;
    step("post_rst_no_done_1", 8'h00, 1'b0, 1'b0);
    step("post_rst_no_done_2", 8'h00, 1'b0, 1'b0);

    // A new burst works after reset
    load(8'h0F);
    mode = SHL; serial_in_l = 1'b1; start = 1'b1; burst_len = 4'd2;
    step("new_burst_capture", 8'h0F, 1'b1, 1'b0);
    start = 1'b0; mode = HOLD;
    step("new_burst_1", 8'h1F, 1'b1, 1'b0);
    step("new_burst_done", 8'h3F, 1'b0, 1'b1);
    step("new_burst_idle", 8'h3F, 1'b0, 1'b0);

    repeat (2) @(negedge clk_2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
